// File: rtl/sme_multi.sv
// String-match engine: buffers one string, then evaluates successive patterns
// (^ $ . and one *) one token per cycle. Define SME_CASE_FOLD_EN for ASCII case-insensitive literals.
module sme_multi #(
  parameter int CHAR_W    = 8,
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    match_len,
  output logic [2:0]        dbg_state
);

  localparam int TOK_W = $clog2(PAT_DEPTH + 1);

  typedef logic [IDX_W:0]    pos_t;
  typedef logic [TOK_W-1:0]  tok_t;
  typedef logic [CHAR_W-1:0] chr_t;

  localparam chr_t C_CARET   = chr_t'(8'h5E);
  localparam chr_t C_DOLLAR  = chr_t'(8'h24);
  localparam chr_t C_DOT     = chr_t'(8'h2E);
  localparam chr_t C_STAR    = chr_t'(8'h2A);
  localparam chr_t C_SPACE   = chr_t'(8'h20);
  localparam pos_t POS_ONE   = pos_t'(1);
  localparam tok_t TOK_ONE   = tok_t'(1);
  localparam pos_t STR_MAX   = pos_t'(STR_DEPTH);
  localparam tok_t PAT_MAX   = tok_t'(PAT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_STR = 3'd1,
    S_LOAD_PAT = 3'd2,
    S_MATCH    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;
  chr_t   str_q [STR_DEPTH];
  chr_t   pat_q [PAT_DEPTH];
  pos_t   str_len_q, str_len_d;
  tok_t   pat_len_q, pat_len_d;
  logic   has_star_q, has_star_d;
  tok_t   star_pos_q, star_pos_d;
  logic   phase_q, phase_d;
  pos_t   start_q, start_d, pos_q, pos_d;
  tok_t   tok_q, tok_d;
  pos_t   pfx_start_q, pfx_start_d, pfx_end_q, pfx_end_d;
  logic   match_q, match_d;
  logic [IDX_W-1:0] index_q, index_d;
  pos_t   mlen_q, mlen_d;

  logic   str_we, pat_we, restart_pat;
  pos_t   str_widx;
  tok_t   pat_widx;
  chr_t   cur_ch, prev_ch, tok_ch;
  logic   in_str, tok_ok, tok_adv;
  logic   finish, found;
  tok_t   seg_begin, seg_end;
  logic   pfx_cons, sfx_cons;
  pos_t   res_idx, res_end;

`ifdef SME_CASE_FOLD_EN
  function automatic logic is_alpha(input chr_t c);
    chr_t l;
    l = c | C_SPACE;
    return (l >= chr_t'(8'h61)) && (l <= chr_t'(8'h7A));
  endfunction
`endif

  function automatic logic lit_eq(input chr_t a, input chr_t b);
    logic eq;
    eq = (a == b);
`ifdef SME_CASE_FOLD_EN
    // Bit 5 is the ASCII case bit; fold it only when both sides are letters.
    if (CHAR_W == 8 && is_alpha(a) && is_alpha(b))
      eq = ((a | C_SPACE) == (b | C_SPACE));
`endif
    return eq;
  endfunction

  // Segment 0 is the prefix (or the whole pattern without '*'); segment 1 is the suffix.
  assign seg_begin = phase_q ? (star_pos_q + TOK_ONE) : '0;
  assign seg_end   = (!phase_q && has_star_q) ? star_pos_q : pat_len_q;
  assign pfx_cons  = phase_q && (pfx_end_q != pfx_start_q);
  assign sfx_cons  = (pos_q != start_q);
  assign res_idx   = pfx_cons ? pfx_start_q : start_q;
  assign res_end   = sfx_cons ? pos_q : (pfx_cons ? pfx_end_q : res_idx);

  always_comb begin
    cur_ch  = '0;
    prev_ch = '0;
    tok_ch  = '0;
    tok_ok  = 1'b0;
    tok_adv = 1'b0;
    for (int i = 0; i < STR_DEPTH; i++) begin
      if (pos_q == pos_t'(i))     cur_ch  = str_q[i];
      if (pos_q == pos_t'(i + 1)) prev_ch = str_q[i];
    end
    for (int i = 0; i < PAT_DEPTH; i++)
      if (tok_q == tok_t'(i)) tok_ch = pat_q[i];
    in_str = (pos_q < str_len_q);
    case (tok_ch)
      C_CARET:  tok_ok = (pos_q == '0) || (prev_ch == C_SPACE);
      C_DOLLAR: tok_ok = !in_str || (cur_ch == C_SPACE);
      C_DOT: begin
        tok_ok  = in_str;
        tok_adv = 1'b1;
      end
      default: begin
        tok_ok  = in_str && lit_eq(cur_ch, tok_ch);
        tok_adv = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    has_star_d  = has_star_q;
    star_pos_d  = star_pos_q;
    phase_d     = phase_q;
    start_d     = start_q;
    pos_d       = pos_q;
    tok_d       = tok_q;
    pfx_start_d = pfx_start_q;
    pfx_end_d   = pfx_end_q;
    match_d     = match_q;
    index_d     = index_q;
    mlen_d      = mlen_q;
    str_we      = 1'b0;
    str_widx    = '0;
    pat_we      = 1'b0;
    pat_widx    = '0;
    restart_pat = 1'b0;
    finish      = 1'b0;
    found       = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD_STR, S_LOAD_PAT: begin
        if (isstring) begin
          state_d  = S_LOAD_STR;
          str_widx = (state_q == S_LOAD_STR) ? str_len_q : '0;
          str_we   = (str_widx < STR_MAX);
          if (str_we) str_len_d = str_widx + POS_ONE;
        end else if (ispattern) begin
          state_d     = S_LOAD_PAT;
          restart_pat = (state_q != S_LOAD_PAT);
          pat_widx    = restart_pat ? '0 : pat_len_q;
          pat_we      = (pat_widx < PAT_MAX);
          if (restart_pat) has_star_d = 1'b0;
          if (pat_we) begin
            pat_len_d = pat_widx + TOK_ONE;
            if (chardata == C_STAR && (restart_pat || !has_star_q)) begin
              has_star_d = 1'b1;
              star_pos_d = pat_widx;
            end
          end
        end else if (state_q == S_LOAD_PAT) begin
          state_d = S_MATCH;
          phase_d = 1'b0;
          start_d = '0;
          pos_d   = '0;
          tok_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MATCH: begin
        if (tok_q == seg_end) begin
          if (!phase_q && has_star_q) begin
            phase_d     = 1'b1;
            pfx_start_d = start_q;
            pfx_end_d   = pos_q;
            start_d     = pos_q;
            tok_d       = star_pos_q + TOK_ONE;
          end else begin
            finish = 1'b1;
            found  = 1'b1;
          end
        end else if (tok_ok) begin
          tok_d = tok_q + TOK_ONE;
          if (tok_adv) pos_d = pos_q + POS_ONE;
        end else if (start_q >= str_len_q) begin
          // A failed suffix cannot succeed from a later prefix: that only narrows its range.
          finish = 1'b1;
        end else begin
          start_d = start_q + POS_ONE;
          pos_d   = start_q + POS_ONE;
          tok_d   = seg_begin;
        end
        if (finish) begin
          state_d = S_DONE;
          match_d = found;
          index_d = found ? res_idx[IDX_W-1:0] : '0;
          mlen_d  = found ? (res_end - res_idx) : '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      has_star_q  <= 1'b0;
      star_pos_q  <= '0;
      phase_q     <= 1'b0;
      start_q     <= '0;
      pos_q       <= '0;
      tok_q       <= '0;
      pfx_start_q <= '0;
      pfx_end_q   <= '0;
      match_q     <= 1'b0;
      index_q     <= '0;
      mlen_q      <= '0;
    end else begin
      state_q     <= state_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      has_star_q  <= has_star_d;
      star_pos_q  <= star_pos_d;
      phase_q     <= phase_d;
      start_q     <= start_d;
      pos_q       <= pos_d;
      tok_q       <= tok_d;
      pfx_start_q <= pfx_start_d;
      pfx_end_q   <= pfx_end_d;
      match_q     <= match_d;
      index_q     <= index_d;
      mlen_q      <= mlen_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STR_DEPTH; i++)
      if (str_we && str_widx == pos_t'(i)) str_q[i] <= chardata;
    for (int i = 0; i < PAT_DEPTH; i++)
      if (pat_we && pat_widx == tok_t'(i)) pat_q[i] <= chardata;
  end

  assign busy        = (state_q == S_MATCH) || (state_q == S_DONE);
  assign valid       = (state_q == S_DONE);
  assign match       = match_q;
  assign match_index = index_q;
  assign match_len   = mlen_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sme_multi.sv
// Bench for sme_multi: directed cases plus random strings/patterns against a
// loop-based reference model of the leftmost-match rules.
module tb_sme_multi;

  localparam int CHAR_W    = 8;
  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int IDX_W     = 5;
  localparam int RW        = 1 + IDX_W + IDX_W + 1;
  localparam int LIMIT     = STR_DEPTH * (PAT_DEPTH + 1) + 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CHAR_W-1:0] chardata = '0;
  logic              isstring = 1'b0;
  logic              ispattern = 1'b0;
  logic              busy, valid, match;
  logic [IDX_W-1:0]  match_index;
  logic [IDX_W:0]    match_len;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  byte m_str[$];
  byte m_pat[$];

  sme_multi #(
    .CHAR_W(CHAR_W), .STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .busy(busy), .valid(valid), .match(match),
    .match_index(match_index), .match_len(match_len), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input bit m, input int idx, input int len);
    logic [IDX_W-1:0] ti;
    logic [IDX_W:0]   tl;
    ti = idx[IDX_W-1:0];
    tl = len[IDX_W:0];
    return {m, ti, tl};
  endfunction

`ifdef SME_CASE_FOLD_EN
  function automatic bit is_letter(input byte c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction
  function automatic byte lower(input byte c);
    return (c >= 8'h41 && c <= 8'h5A) ? byte'(c + 8'd32) : c;
  endfunction
`endif

  function automatic bit ch_eq(input byte a, input byte b);
`ifdef SME_CASE_FOLD_EN
    if (is_letter(a) && is_letter(b)) return lower(a) == lower(b);
`endif
    return a == b;
  endfunction

  // Try pattern tokens [b,e) starting at string position p; endp is where it stops.
  function automatic bit seg_ok(input int p, input int b, input int e, output int endp);
    int pos = p;
    int len = m_str.size();
    endp = p;
    for (int k = b; k < e; k++) begin
      if (m_pat[k] == 8'h5E) begin
        if (!(pos == 0 || m_str[pos-1] == 8'h20)) return 1'b0;
      end else if (m_pat[k] == 8'h24) begin
        if (!(pos == len || m_str[pos] == 8'h20)) return 1'b0;
      end else begin
        if (pos >= len) return 1'b0;
        if (m_pat[k] != 8'h2E && !ch_eq(m_str[pos], m_pat[k])) return 1'b0;
        pos++;
      end
    end
    endp = pos;
    return 1'b1;
  endfunction

  function automatic logic [RW-1:0] ref_result();
    int n = m_pat.size();
    int len = m_str.size();
    int s = -1;
    int e1, e2, idx, lend;
    for (int k = 0; k < n; k++)
      if (m_pat[k] == 8'h2A && s < 0) s = k;
    for (int p = 0; p <= len; p++) begin
      if (s < 0) begin
        if (seg_ok(p, 0, n, e1)) return pack(1'b1, p, e1 - p);
      end else if (seg_ok(p, 0, s, e1)) begin
        for (int q = e1; q <= len; q++) begin
          if (seg_ok(q, s + 1, n, e2)) begin
            idx  = (e1 > p) ? p : q;
            lend = (e2 > q) ? e2 : ((e1 > p) ? e1 : idx);
            return pack(1'b1, idx, lend - idx);
          end
        end
      end
    end
    return pack(1'b0, 0, 0);
  endfunction

  task automatic drive_str(input string s, input bit with_pat);
    m_str.delete();
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      isstring  = 1'b1;
      ispattern = with_pat;
      chardata  = s[i];
      if (i < STR_DEPTH) m_str.push_back(s[i]);
    end
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = '0;
  endtask

  task automatic drive_pat(input string s);
    m_pat.delete();
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ispattern = 1'b1;
      chardata  = s[i];
      if (i < PAT_DEPTH) m_pat.push_back(s[i]);
    end
    @(negedge clk);
    ispattern = 1'b0;
    chardata  = '0;
  endtask

  task automatic run_pat(input string p, output logic [RW-1:0] got);
    logic [RW-1:0] exp;
    bit seen = 1'b0;
    got = '0;
    drive_pat(p);
    exp_q.push_back(ref_result());
    @(negedge clk);
    check("busy_hi", busy, 1);
    for (int c = 0; c < LIMIT; c++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      check({"timeout ", p}, 0, 1);
    end else begin
      got = {match, match_index, match_len};
      check({"result ", p}, got, exp);
      @(negedge clk);
      check("valid_pulse", valid, 0);
      check("busy_lo", busy, 0);
      check("hold", {match, match_index, match_len}, exp);
    end
  endtask

  function automatic string rand_text(input int n, input string alpha);
    string s = "";
    for (int i = 0; i < n; i++)
      s = $sformatf("%s%c", s, alpha[$urandom_range(alpha.len() - 1, 0)]);
    return s;
  endfunction

  initial begin
    logic [RW-1:0] r;
    string s40;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_outs", {valid, busy, match, match_index, match_len}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, 0);

    drive_str("the cat sat", 1'b0);
    run_pat("cat", r);
    check("tp_cat", r, pack(1'b1, 4, 3));
    run_pat("^sat$", r);
    check("tp_sat_anch", r, pack(1'b1, 8, 3));
    run_pat("^at", r);
    check("tp_no_match", r, pack(1'b0, 0, 0));

    drive_str("abcxxdef", 1'b0);
    run_pat("b*de", r);
    check("tp_star", r, pack(1'b1, 1, 6));
    run_pat("*", r);
    check("tp_star_only", r, pack(1'b1, 0, 0));

    s40 = "";
    for (int i = 0; i < 40; i++) s40 = {s40, "a"};
    drive_str(s40, 1'b0);
    run_pat("a$", r);
    check("tp_sat_len", r, pack(1'b1, 31, 1));
    run_pat("aaaaaaaaz", r);
    check("tp_pat_trunc", r, pack(1'b1, 0, 8));

    drive_str("xcat", 1'b1);
    run_pat("cat", r);
    check("tp_str_wins", r, pack(1'b1, 1, 3));

    drive_str(s40, 1'b0);
    drive_pat("aaaaaaab");
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {valid, busy, match, match_index, match_len}, 0);
    check("mid_rst_state", dbg_state, 0);
    reset = 1'b0;
    m_str.delete();
    m_pat.delete();
    seen = 0;
    for (int c = 0; c < LIMIT + 20; c++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("rst_no_valid", seen, 0);

    drive_str("the", 1'b0);
    run_pat("t.e", r);
    check("tp_dot", r, pack(1'b1, 0, 3));

    drive_str("Hello", 1'b0);
    run_pat("hEL", r);
`ifdef SME_CASE_FOLD_EN
    check("tp_fold", r, pack(1'b1, 0, 3));
`else
    check("tp_fold", r, pack(1'b0, 0, 0));
`endif

    for (int t = 0; t < 40; t++) begin
      if (t == 0 || $urandom_range(2, 0) == 0)
        drive_str(rand_text($urandom_range(40, 1), "abB  c"), 1'b0);
      run_pat(rand_text($urandom_range(10, 1), "ab .^$*"), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
